gaa_sdram_reader: RTL and testbench

- Avalon-MM pipelined read master inside soc_system that fetches a contiguous block of 16-bit words from the SDRAM controller driving the DRAM_* pins.
- Words are presented in order on a valid/ready stream to the GAA compute datapath.
- Bounds outstanding reads with a credit scheme so the internal output buffer can never overflow, regardless of downstream stalls.

---
 rtl/gaa_pkg.sv | 14 +
 rtl/gaa_sync_fifo.sv | 67 ++++++
 rtl/gaa_sdram_reader.sv | 159 +++++++++++++++
 tb/tb_gaa_sdram_reader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaa_pkg.sv
// Shared types and SDRAM geometry for the GAA SDRAM block reader.
package gaa_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

endpackage

// File: rtl/gaa_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible while not empty.
module gaa_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push    = push_i && (!full || do_pop);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && full && !do_pop));

endmodule

// File: rtl/gaa_sdram_reader.sv
// Avalon-MM pipelined read master streaming a contiguous SDRAM block to the GAA datapath.
//   state  | meaning
//   IDLE   | waiting for start; stale read returns are dropped
//   ISSUE  | issuing reads while credit (FIFO space minus outstanding) allows
//   DRAIN  | all reads accepted; waiting for returns and for the FIFO to empty
//   FINISH | transfer complete; done is raised on the following cycle
module gaa_sdram_reader
  import gaa_pkg::*;
#(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ISSUE  = ISSUE;
  localparam logic [1:0] S_DRAIN  = DRAIN;
  localparam logic [1:0] S_FINISH = FINISH;

  localparam int CNT_W = LEN_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  received_q, received_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              read_q, read_d;
  logic              done_q, done_d;

  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty;
  logic              accept;
  logic              active;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  fifo_next;
  logic              credit_ok;

  assign active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign accept      = read_q && !avm_waitrequest;
  assign push        = avm_readdatavalid && active;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign busy        = active;
  assign done        = done_q;
  assign avm_address = addr_q;
  assign avm_read    = read_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;
    read_d        = 1'b0;
    fifo_next     = '0;
    credit_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d         = {1'b0, length};
          addr_d        = base_addr;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          state_d       = (length == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((received_q == len_q) && fifo_empty) state_d = S_FINISH;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase

    if (active) begin
      if (accept && !push)      outstanding_d = outstanding_q + CNT_W'(1);
      else if (!accept && push) outstanding_d = outstanding_q - CNT_W'(1);
      if (push) received_d = received_q + CNT_W'(1);
    end

    // Credit is judged on next-cycle occupancy because avm_read is registered.
    fifo_next = SUM_W'(fifo_count) + SUM_W'(push) - SUM_W'(pop);
    credit_ok = (fifo_next + SUM_W'(outstanding_d)) < SUM_W'(FIFO_DEPTH);

    if (state_d == S_ISSUE) begin
      read_d = (read_q && avm_waitrequest) || ((issued_d < len_d) && credit_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      read_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      read_q        <= read_d;
      done_q        <= done_d;
    end
  end

  gaa_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (avm_readdata),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_gaa_sdram_reader.sv
// Randomized bench for gaa_sdram_reader with a behavioural SDRAM slave and stream sink.
module tb_gaa_sdram_reader;

  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  gaa_sdram_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rsp_t;

  int            cyc = 0;
  int            lat = 2;
  int            wait_pct = 0;
  int            ready_pct = 100;
  int            stall_at = -1;
  int            stall_left = 0;
  bit            stall_begun = 0;
  int            stall_bad = 0;
  logic [AW-1:0] stall_addr = '0;
  rsp_t          pend[$];
  rsp_t          cur_rsp;
  logic [AW-1:0] acc_addr[$];
  int            acc_cyc[$];
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  int            done_cnt = 0, done_cyc = -1, start_cyc = -1;
  int            inflight = 0, max_inflight = 0, read_cycles = 0;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[24:16], 7'h35};
  endfunction

  // Slave, sink and event monitor all act mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    out_ready = ($urandom_range(0, 99) < ready_pct);
    avm_waitrequest = 1'b0;
    if (stall_left > 0 && acc_addr.size() == stall_at && (avm_read || stall_begun)) begin
      stall_begun = 1;
      avm_waitrequest = 1'b1;
      stall_left--;
      if (avm_read !== 1'b1 || avm_address !== stall_addr) stall_bad++;
    end else if (avm_read && $urandom_range(0, 99) < wait_pct) begin
      avm_waitrequest = 1'b1;
    end
    if (avm_read) read_cycles++;
    if (avm_read && !avm_waitrequest) begin
      acc_addr.push_back(avm_address);
      acc_cyc.push_back(cyc);
      pend.push_back('{due: cyc + lat, addr: avm_address});
      inflight++;
    end
    avm_readdatavalid = 1'b0;
    avm_readdata = DW'($urandom);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      cur_rsp = pend.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata = mem_word(cur_rsp.addr);
    end
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
      inflight--;
    end
    if (inflight > max_inflight) max_inflight = inflight;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start) start_cyc = cyc;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete(); got.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    done_cnt = 0; done_cyc = -1; start_cyc = -1;
    inflight = 0; max_inflight = 0; read_cycles = 0;
    stall_begun = 0; stall_bad = 0;
  endtask

  // Reference: word i of a transfer comes from address base+i modulo 2^AW.
  task automatic model_xfer(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem_word(a));
    end
  endtask

  function automatic int stream_errs();
    int n = (got.size() == exp_data.size()) ? 0 : 1;
    for (int i = 0; i < got.size() && i < exp_data.size(); i++)
      if (got[i] !== exp_data[i]) n++;
    return n;
  endfunction

  function automatic int addr_errs();
    int n = (acc_addr.size() == exp_addr.size()) ? 0 : 1;
    for (int i = 0; i < acc_addr.size() && i < exp_addr.size(); i++)
      if (acc_addr[i] !== exp_addr[i]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    base_addr = AW'($urandom);
    length = LW'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    tick(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({busy, done, avm_read, out_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/read/valid=%b required 0000", {busy, done, avm_read, out_valid});
    end
    checks++;
    if (avm_address !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h required 0/0", avm_address, out_data);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    bit ok;
    lat = 2; wait_pct = 0; ready_pct = 100;
    clear_logs();
    model_xfer(25'h0000100, 4);
    pulse_start(25'h0000100, 16'd4);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: no done seen, required one"); end
    checks++;
    if (addr_errs() != 0) begin
      errors++; $display("FAIL basic_addr: %0d address errors over %0d reads, required 0", addr_errs(), acc_addr.size());
    end
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] !== start_cyc + 1 + i) begin
        errors++; $display("FAIL basic_issue_cycle[%0d]: offset %0d required %0d", i, acc_cyc[i] - start_cyc, 1 + i);
      end
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] !== start_cyc + 4) begin
      errors++; $display("FAIL basic_latency: first word not at start+4 (got %0d words)", got_cyc.size());
    end
    checks++;
    if (stream_errs() != 0) begin
      errors++; $display("FAIL basic_data: %0d errors, got %0d words required %0d", stream_errs(), got.size(), exp_data.size());
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_end: done_cnt=%0d busy=%b required 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_credit();
    bit ok;
    logic [AW-1:0] b = AW'($urandom);
    lat = 2; wait_pct = 0; ready_pct = 0;
    clear_logs();
    model_xfer(b, 20);
    pulse_start(b, 16'd20);
    tick(40);
    checks++;
    if (acc_addr.size() !== DEPTH) begin
      errors++; $display("FAIL credit_stop: %0d reads accepted, required %0d", acc_addr.size(), DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data[0]) begin
      errors++; $display("FAIL credit_hold: valid=%b data=%h required 1/%h", out_valid, out_data, exp_data[0]);
    end
    ready_pct = 100;
    wait_done(400, ok);
    checks++;
    if (!ok || stream_errs() != 0 || addr_errs() != 0) begin
      errors++; $display("FAIL credit_data: done=%b got %0d words, %0d data errors, required 20 clean", ok, got.size(), stream_errs());
    end
    checks++;
    if (max_inflight > DEPTH) begin
      errors++; $display("FAIL credit_bound: max in flight %0d, required <= %0d", max_inflight, DEPTH);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [AW-1:0] b = AW'($urandom);
    lat = 2; wait_pct = 0; ready_pct = 100;
    clear_logs();
    model_xfer(b, 6);
    stall_at = 1; stall_left = 3; stall_addr = b + AW'(1);
    pulse_start(b, 16'd6);
    wait_done(200, ok);
    checks++;
    if (stall_left !== 0 || stall_bad !== 0) begin
      errors++; $display("FAIL stall_hold: stall_left=%0d bad=%0d required 0/0", stall_left, stall_bad);
    end
    checks++;
    if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 4) begin
      errors++; $display("FAIL stall_gap: second read gap wrong (reads=%0d), required 4 cycles", acc_cyc.size());
    end
    checks++;
    if (!ok || addr_errs() != 0 || stream_errs() != 0) begin
      errors++; $display("FAIL stall_seq: done=%b addr errs %0d data errs %0d required 0", ok, addr_errs(), stream_errs());
    end
    stall_at = -1;
  endtask

  task automatic test_wrap();
    bit ok;
    lat = 3; wait_pct = 0; ready_pct = 100;
    clear_logs();
    model_xfer(25'h1FFFFFE, 4);
    pulse_start(25'h1FFFFFE, 16'd4);
    wait_done(200, ok);
    checks++;
    if (acc_addr.size() != 4 || acc_addr[1] !== 25'h1FFFFFF || acc_addr[2] !== 25'h0 || acc_addr[3] !== 25'h1) begin
      errors++; $display("FAIL wrap_addr: %0d reads, required 1FFFFFE,1FFFFFF,0,1", acc_addr.size());
    end
    checks++;
    if (!ok || stream_errs() != 0) begin
      errors++; $display("FAIL wrap_data: done=%b data errs %0d required 0", ok, stream_errs());
    end
  endtask

  task automatic test_len0();
    clear_logs();
    pulse_start(AW'($urandom), 16'd0);
    tick(6);
    checks++;
    if (done_cnt !== 1 || done_cyc - start_cyc !== 2) begin
      errors++; $display("FAIL len0_done: count=%0d offset=%0d required 1/2", done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (read_cycles !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_idle: read cycles=%0d busy=%b required 0/0", read_cycles, busy);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [AW-1:0] b = AW'($urandom);
    lat = 2; wait_pct = 10; ready_pct = 50;
    clear_logs();
    model_xfer(b, 6);
    pulse_start(b, 16'd6);
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: busy=%b required 1", busy); end
    pulse_start(b + AW'(1000), 16'd9);
    wait_done(400, ok);
    tick(20);
    checks++;
    if (!ok || done_cnt !== 1 || addr_errs() != 0 || stream_errs() != 0) begin
      errors++; $display("FAIL start_ignored: done=%0d reads=%0d words=%0d required 1/6/6", done_cnt, acc_addr.size(), got.size());
    end
    wait_pct = 0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    logic [AW-1:0] b = 25'h0123400;
    lat = 4; wait_pct = 0; ready_pct = 100;
    clear_logs();
    pulse_start(25'h0777700, 16'd10);
    for (int i = 0; i < 30 && acc_addr.size() < 3; i++) tick(1);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, avm_read, out_valid} !== 4'b0 || avm_address !== '0 || out_data !== '0) begin
      errors++; $display("FAIL abort_outputs: ctrl=%b addr=%h data=%h required zeros",
                         {busy, done, avm_read, out_valid}, avm_address, out_data);
    end
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 20 && pend.size() > 0; i++) tick(1);
    tick(2);
    checks++;
    if (out_valid !== 1'b0 || done_cnt !== 0) begin
      errors++; $display("FAIL abort_stale: valid=%b done_cnt=%0d required 0/0", out_valid, done_cnt);
    end
    lat = 2;
    clear_logs();
    model_xfer(b, 5);
    pulse_start(b, 16'd5);
    wait_done(200, ok);
    checks++;
    if (!ok || addr_errs() != 0 || stream_errs() != 0) begin
      errors++; $display("FAIL abort_restart: done=%b words=%0d data errs %0d required 5 clean", ok, got.size(), stream_errs());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [AW-1:0] b;
    int n;
    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(1, 4);
      wait_pct = $urandom_range(0, 40);
      ready_pct = $urandom_range(20, 100);
      b = AW'($urandom);
      if ($urandom_range(0, 2) == 0) b = '1 - AW'($urandom_range(0, 10));
      n = $urandom_range(1, 40);
      clear_logs();
      model_xfer(b, n);
      pulse_start(b, LW'(n));
      wait_done(3000, ok);
      checks++;
      if (!ok || done_cnt !== 1) begin
        errors++; $display("FAIL rand%0d_done: done=%b count=%0d required 1", it, ok, done_cnt);
      end
      checks++;
      if (addr_errs() != 0 || stream_errs() != 0) begin
        errors++; $display("FAIL rand%0d_seq: len %0d addr errs %0d data errs %0d required 0", it, n, addr_errs(), stream_errs());
      end
      checks++;
      if (max_inflight > DEPTH) begin
        errors++; $display("FAIL rand%0d_bound: in flight %0d required <= %0d", it, max_inflight, DEPTH);
      end
    end
    wait_pct = 0;
    ready_pct = 100;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_stall();
    test_wrap();
    test_len0();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
